// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between the gate truth checker and the network it exercises.
// The checker owns the slave side; whoever hosts the gate network owns the master side.
interface gate_truth_checker_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 3
);
  logic             start;
  logic             r;
  logic [N_IN-1:0]  vec;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [N_IN-1:0]  fail_vec;
  logic             fail_valid;

  modport master (
    output start, r,
    input  vec, busy, done, pass, err_count, fail_vec, fail_valid
  );

  modport slave (
    input  start, r,
    output vec, busy, done, pass, err_count, fail_vec, fail_valid
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps every input combination of a small gate network, waits a settle time per vector
// and checks the response against a truth table, keeping error count and first failing vector.
module gate_truth_checker #(
  parameter int                   N_IN   = 2,
  parameter logic [(2**N_IN)-1:0] TRUTH  = 4'b0111,
  parameter int                   SETTLE = 1,
  parameter int                   CNT_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_truth_checker_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [N_IN-1:0]  vec;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [N_IN-1:0]  fail_vec;
  logic             fail_valid;
  logic             expected_bit;
  logic             mismatch;

  assign expected_bit = TRUTH[vec];

  // Anything other than a clean 0/1 equal to the expected bit is a mismatch.
  always_comb begin
    mismatch = 1'b1;
    case (bus.r)
      1'b0:    mismatch = expected_bit;
      1'b1:    mismatch = !expected_bit;
      default: mismatch = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          vec <= '0;
          if (bus.start) begin
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (err_count != {CNT_W{1'b1}}) begin
              err_count <= err_count + 1'b1;
            end
            if (!fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
          end
          // The next vector is presented on the same edge that enters DRIVE.
          if (vec == LAST_VEC) begin
            state <= ST_FINISH;
          end else begin
            vec   <= vec + 1'b1;
            state <= ST_DRIVE;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0);
          vec   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          vec   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec        = vec;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.fail_vec   = fail_vec;
  assign bus.fail_valid = fail_valid;

endmodule
